// File: rtl/a2pdp_pkg.sv
// Shared types and widths for the PDP-11/Apple II bridge RAM path.
package a2pdp_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_ACK} arb_state_t;
  typedef enum logic {SEL_CPU, SEL_HOST} arb_sel_t;

  localparam int ADDR_W = 22;
  localparam int DATA_W = 16;
  // First word of the 22-bit I/O page.
  localparam logic [ADDR_W-1:0] HIMEM = 22'o17760000;

  // Host byte writes present the byte on both lanes; the RAM picks one by addr[0].
  function automatic logic [DATA_W-1:0] lane_dup(input logic be, input logic [DATA_W-1:0] d);
    return be ? {d[7:0], d[7:0]} : d;
  endfunction

endpackage

// File: rtl/ram_arbiter.sv
// Two-requester (CPU, host) arbiter for the single PSRAM controller port:
// issue -> wait-for-done -> ack, CPU priority with bounded host starvation, access timeout.
module ram_arbiter
  import a2pdp_pkg::*;
#(
  parameter int MAX_CPU_STREAK = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ram_init,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic              cpu_byte,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic              host_byte,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic              mem_byte,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_done,
  output logic              grant_host,
  output logic              timeout_err
);

  localparam logic [3:0] STREAK_MAX = 4'(MAX_CPU_STREAK);
  localparam logic [7:0] TMO_LIMIT  = 8'(TIMEOUT_CYCLES);

  arb_state_t state, state_nx;
  arb_sel_t   sel;
  logic [3:0] streak;
  logic [7:0] tmo_cnt;
  logic       grant, pick_host, tmo_hit, finish;

  assign grant     = (state == ARB_IDLE) && ram_init && (cpu_req || host_req);
  assign pick_host = host_req && (!cpu_req || (streak == STREAK_MAX));
  assign tmo_hit   = (tmo_cnt == TMO_LIMIT);
  assign finish    = (state == ARB_WAIT) && (mem_done || tmo_hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ARB_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ARB_IDLE:  if (grant)  state_nx = ARB_ISSUE;
      ARB_ISSUE:             state_nx = ARB_WAIT;
      ARB_WAIT:  if (finish) state_nx = ARB_ACK;
      ARB_ACK:               state_nx = ARB_IDLE;
      default:               state_nx = ARB_IDLE;
    endcase
  end

  // Counts WAIT cycles from 0; expiry lands in the (TIMEOUT_CYCLES+1)th WAIT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 tmo_cnt <= '0;
    else if (state != ARB_WAIT) tmo_cnt <= '0;
    else if (!tmo_hit)          tmo_cnt <= tmo_cnt + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) streak <= '0;
    else if (state == ARB_IDLE) begin
      if (!host_req)                streak <= '0;
      else if (grant && pick_host)  streak <= '0;
      else if (grant && streak != STREAK_MAX) streak <= streak + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel         <= SEL_CPU;
      grant_host  <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_byte    <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      cpu_ack     <= 1'b0;
      host_ack    <= 1'b0;
      cpu_rdata   <= '0;
      host_rdata  <= '0;
      timeout_err <= 1'b0;
    end else begin
      mem_read <= 1'b0;
      mem_write <= 1'b0;
      cpu_ack  <= 1'b0;
      host_ack <= 1'b0;
      case (state)
        ARB_IDLE: if (grant) begin
          sel        <= pick_host ? SEL_HOST : SEL_CPU;
          grant_host <= pick_host;
          if (pick_host) begin
            mem_addr  <= host_addr;
            mem_wdata <= lane_dup(host_byte, host_wdata);
            mem_byte  <= host_byte;
            mem_read  <= !host_we;
            mem_write <= host_we;
          end else begin
            mem_addr  <= cpu_addr;
            mem_wdata <= cpu_wdata;
            mem_byte  <= cpu_byte;
            mem_read  <= !cpu_we;
            mem_write <= cpu_we;
          end
        end
        ARB_WAIT: if (finish) begin
          // mem_done takes precedence over a timeout expiring in the same cycle.
          if (sel == SEL_HOST) begin
            host_rdata <= mem_done ? mem_rdata : {DATA_W{1'b1}};
            host_ack   <= 1'b1;
          end else begin
            cpu_rdata <= mem_done ? mem_rdata : {DATA_W{1'b1}};
            cpu_ack   <= 1'b1;
          end
          if (!mem_done) timeout_err <= 1'b1;
        end
        ARB_ACK: grant_host <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized + directed bench for ram_arbiter against a timestamp-based access model.
module tb_ram_arbiter;
  localparam int MAXS = 4;
  localparam int T    = 16;

  logic        clk = 1'b0, rst_n = 1'b1, ram_init = 1'b0;
  logic        cpu_req = 0, cpu_we = 0, cpu_byte = 0;
  logic [21:0] cpu_addr = 0;
  logic [15:0] cpu_wdata = 0;
  logic        cpu_ack;
  logic [15:0] cpu_rdata;
  logic        host_req = 0, host_we = 0, host_byte = 0;
  logic [21:0] host_addr = 0;
  logic [15:0] host_wdata = 0;
  logic        host_ack;
  logic [15:0] host_rdata;
  logic        mem_read, mem_write, mem_byte;
  logic [21:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = 0;
  logic        mem_done = 0;
  logic        grant_host, timeout_err;

  ram_arbiter #(.MAX_CPU_STREAK(MAXS), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .ram_init(ram_init),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_byte(cpu_byte), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_we(host_we), .host_byte(host_byte), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_byte(mem_byte), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .grant_host(grant_host), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int checks = 0, passes = 0;
  bit cmp_en = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- reference model: one access described by its grant/ack timestamps
  int          mk = 0, g = 0, ack_c = 0, streak = 0;
  bit          busy = 0, acked = 0, who = 0, m_we = 0, m_byte = 0;
  logic [21:0] m_addr = 0;
  logic [15:0] m_wdata = 0, e_crd = 0, e_hrd = 0;
  bit          e_rd = 0, e_wr = 0, e_cack = 0, e_hack = 0, e_gh = 0, e_err = 0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      busy = 0; acked = 0; streak = 0; m_addr = 0; m_wdata = 0; m_byte = 0;
      e_crd = 0; e_hrd = 0; e_err = 0; e_rd = 0; e_wr = 0; e_cack = 0; e_hack = 0; e_gh = 0;
    end else begin
      mk++;
      if (!busy) begin
        if (ram_init && (cpu_req || host_req)) begin
          who    = host_req && (!cpu_req || streak == MAXS);
          busy   = 1; acked = 0; g = mk;
          m_we   = who ? host_we : cpu_we;
          m_byte = who ? host_byte : cpu_byte;
          m_addr = who ? host_addr : cpu_addr;
          m_wdata = who ? (host_byte ? {2{host_wdata[7:0]}} : host_wdata) : cpu_wdata;
          if (who) streak = 0;
          else if (host_req) streak = (streak < MAXS) ? streak + 1 : streak;
          else streak = 0;
        end else if (!host_req) streak = 0;
      end else if (!acked) begin
        if (mk - 1 >= g + 1) begin
          if (mem_done) begin
            acked = 1; ack_c = mk;
            if (who) e_hrd = mem_rdata; else e_crd = mem_rdata;
          end else if (mk - 1 == g + 1 + T) begin
            acked = 1; ack_c = mk; e_err = 1;
            if (who) e_hrd = 16'hFFFF; else e_crd = 16'hFFFF;
          end
        end
      end else if (mk == ack_c + 1) busy = 0;
      e_rd   = busy && mk == g && !m_we;
      e_wr   = busy && mk == g && m_we;
      e_cack = busy && acked && mk == ack_c && !who;
      e_hack = busy && acked && mk == ack_c && who;
      e_gh   = busy && who;
    end
  end

  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      chk("mem_read", mem_read, e_rd);
      chk("mem_write", mem_write, e_wr);
      chk("cpu_ack", cpu_ack, e_cack);
      chk("host_ack", host_ack, e_hack);
      chk("grant_host", grant_host, e_gh);
      chk("timeout_err", timeout_err, e_err);
      chk("cpu_rdata", cpu_rdata, e_crd);
      chk("host_rdata", host_rdata, e_hrd);
      if (busy || !rst_n) begin
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_wdata", mem_wdata, m_wdata);
        chk("mem_byte", mem_byte, m_byte);
      end
    end
  end

  // ---------------- RAM responder: 0 fixed delay, 1 never answers, 2 random (incl. spurious)
  int          resp_mode = 0, resp_d = 1, done_at = -1, rsp_r = 0, rsp_dly = 0;
  logic [15:0] resp_data = 0;

  initial forever begin
    @(negedge clk);
    mem_done = 1'b0;
    if (cyc == done_at) begin
      mem_done  = 1'b1;
      mem_rdata = (resp_mode == 2) ? 16'($urandom) : resp_data;
    end else if (resp_mode == 2 && $urandom_range(30) == 0) begin
      mem_done  = 1'b1;
      mem_rdata = 16'($urandom);
    end
    if ((mem_read || mem_write) && resp_mode != 1) begin
      rsp_r   = $urandom_range(9);
      rsp_dly = (rsp_r < 7) ? 1 + rsp_r % 4 : (rsp_r == 7 ? T + 1 : T + 3);
      done_at = cyc + ((resp_mode == 2) ? rsp_dly : resp_d);
    end
  end

  // ---------------- stimulus
  int          s, a, c0, n, nstb, nack;
  bit          s_rd, s_wr, s_byte, s_gh, a_gh;
  logic [21:0] s_addr;
  logic [15:0] s_wdata;
  logic [9:0]  seq;

  task automatic drive_step(input bit rnd, input bit hold_c, input bit hold_h);
    if (cpu_ack && !hold_c) cpu_req = 0;
    else if (rnd && !cpu_req && $urandom_range(3) == 0) begin
      cpu_we = 1'($urandom); cpu_byte = 1'($urandom);
      cpu_addr = 22'($urandom); cpu_wdata = 16'($urandom); cpu_req = 1;
    end
    if (host_ack && !hold_h) host_req = 0;
    else if (rnd && !host_req && $urandom_range(3) == 0) begin
      host_we = 1'($urandom); host_byte = 1'($urandom);
      host_addr = 22'($urandom); host_wdata = 16'($urandom); host_req = 1;
    end
    if (rnd) ram_init = ($urandom_range(15) != 0);
  endtask

  task automatic access(input bit h, input bit we, input bit be, input logic [21:0] ad,
                        input logic [15:0] d);
    s = -1; a = -1;
    @(negedge clk);
    if (h) begin host_we = we; host_byte = be; host_addr = ad; host_wdata = d; host_req = 1; end
    else   begin cpu_we = we; cpu_byte = be; cpu_addr = ad; cpu_wdata = d; cpu_req = 1; end
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (s < 0 && (mem_read || mem_write)) begin
        s = cyc; s_rd = mem_read; s_wr = mem_write; s_byte = mem_byte;
        s_addr = mem_addr; s_wdata = mem_wdata; s_gh = grant_host;
      end
      if (h ? host_ack : cpu_ack) begin
        a = cyc; a_gh = grant_host;
        if (h) host_req = 0; else cpu_req = 0;
        break;
      end
    end
    chk("ack_arrives", a >= 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ram_init = 1;
    #1 rst_n = 0;
    repeat (2) @(negedge clk);
    chk("reset_ctrl", {mem_read, mem_write, cpu_ack, host_ack, grant_host, timeout_err, mem_byte}, 0);
    chk("reset_bus", {mem_addr, mem_wdata, cpu_rdata}, 0);
    cmp_en = 1;
    @(negedge clk);
    rst_n = 1;

    // CPU read, done 3 cycles after strobe
    resp_mode = 0; resp_d = 3; resp_data = 16'o123456;
    access(0, 0, 0, 22'o1000, 16'h0000);
    chk("t1_strobe_is_read", {s_rd, s_wr}, 2'b10);
    chk("t1_addr", s_addr, 22'o1000);
    chk("t1_strobe_to_ack", a - s, 4);
    chk("t1_rdata", cpu_rdata, 16'o123456);

    // host byte write
    resp_d = 2;
    access(1, 1, 1, 22'o1001, 16'h00A5);
    chk("t2_strobe_is_write", {s_rd, s_wr}, 2'b01);
    chk("t2_byte", s_byte, 1);
    chk("t2_wdata", s_wdata, 16'hA5A5);
    chk("t2_grant_host_issue", s_gh, 1);
    chk("t2_grant_host_ack", a_gh, 1);
    chk("t2_strobe_to_ack", a - s, 3);
    @(negedge clk);
    chk("t2_grant_host_cleared", grant_host, 0);

    // done lands exactly in the expiry cycle: done wins
    resp_d = T + 1; resp_data = 16'h1234;
    access(0, 0, 0, 22'o2000, 16'h0000);
    chk("tx_expiry_ack", a - s, T + 2);
    chk("tx_expiry_rdata", cpu_rdata, 16'h1234);
    chk("tx_expiry_no_err", timeout_err, 0);

    // both held: starvation bound and streak reset
    resp_d = 1; n = 0; seq = '0;
    @(negedge clk);
    cpu_we = 0; host_we = 0; host_byte = 0; cpu_req = 1; host_req = 1;
    for (int i = 0; i < 200 && n < 10; i++) begin
      @(negedge clk);
      drive_step(0, 1, 1);
      if (mem_read || mem_write) begin seq[n] = grant_host; n++; end
    end
    chk("t3_grant_seq", seq, 10'b1000010000);
    repeat (60) begin @(negedge clk); drive_step(0, 0, 0); end

    // ram_init low blocks everything
    @(negedge clk);
    ram_init = 0; cpu_req = 1; host_req = 1; nstb = 0; nack = 0;
    repeat (20) begin
      @(negedge clk);
      if (mem_read || mem_write) nstb++;
      if (cpu_ack || host_ack) nack++;
    end
    chk("t5_no_strobe", nstb, 0);
    chk("t5_no_ack", nack, 0);
    ram_init = 1; c0 = cyc;
    @(negedge clk);
    chk("t5_first_grant_cycle", (mem_read || mem_write) ? cyc - c0 : -1, 1);
    chk("t5_first_grant_cpu", grant_host, 0);
    repeat (40) begin @(negedge clk); drive_step(0, 0, 0); end

    // RAM never answers
    resp_mode = 1;
    access(0, 0, 0, 22'o3000, 16'h0000);
    chk("t4_timeout_ack", a - s, T + 2);
    chk("t4_timeout_rdata", cpu_rdata, 16'hFFFF);
    chk("t4_err_set", timeout_err, 1);
    resp_mode = 0; resp_d = 1; resp_data = 16'hBEEF;
    access(0, 0, 0, 22'o3002, 16'h0000);
    chk("t4_good_rdata", cpu_rdata, 16'hBEEF);
    chk("t4_err_sticky", timeout_err, 1);

    // reset during WAIT
    resp_d = 6; resp_data = 16'h5555; s = -1;
    @(negedge clk);
    cpu_we = 0; cpu_addr = 22'o4000; cpu_req = 1;
    for (int i = 0; i < 20 && s < 0; i++) begin
      @(negedge clk);
      if (mem_read) s = cyc;
    end
    chk("t6_strobe_seen", s >= 0, 1);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 0; cpu_req = 0;
    #1;
    chk("t6_async_ctrl", {mem_read, cpu_ack, grant_host, timeout_err}, 0);
    chk("t6_async_addr", mem_addr, 0);
    @(negedge clk);
    #1 rst_n = 1;
    nack = 0;
    repeat (12) begin @(negedge clk); if (cpu_ack || host_ack) nack++; end
    chk("t6_no_ack_after_reset", nack, 0);
    chk("t6_late_done_ignored", cpu_rdata, 0);
    resp_d = 2; resp_data = 16'h0F0F;
    access(0, 0, 0, 22'o4002, 16'h0000);
    chk("t6_next_rdata", cpu_rdata, 16'h0F0F);
    chk("t6_next_latency", a - s, 3);

    // randomized traffic against the model
    resp_mode = 2;
    for (int i = 0; i < 3000; i++) begin @(negedge clk); drive_step(1, 0, 0); end
    ram_init = 1;
    repeat (120) begin @(negedge clk); drive_step(0, 0, 0); end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
